axi_master_port: RTL
====================

# axi_master_port

AXI4 master port that turns a simple CPU-side memory request (instruction fetch or load/store) into one AXI read burst or one single-beat AXI write. It sits between a CPU memory port and the AXI interconnect, opposite the slave wrappers (ROM/SRAM), and drives the AW/W/AR channels while accepting the B/R channels. One transaction is outstanding at a time. The CPU is stalled until that transaction completes.

## Interface
- MASTER_ID, default 4'd0: value driven on AWID/ARID.
- ACLK  in  1  clock.
- ARESET  in  1  synchronous, active-high reset.
- cpu_req  in  1  request valid; sampled in IDLE.
- cpu_write  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_len  in  4  read burst length minus 1; ignored for writes.
- cpu_wdata  in  32  write data.
- cpu_wstrb  in  4  active-high byte enables.
- cpu_stall  out  1  CPU must hold its request.
- cpu_rdata  out  32  read beat data.
- cpu_rvalid  out  1  cpu_rdata valid this cycle.
- cpu_done  out  1  transaction complete (one-cycle pulse).
- cpu_err  out  1  sticky response error (see Configuration).
- M_AWID/AWAddr/AWLen/AWSize/AWBurst/AWValid  out  4/32/4/3/2/1; M_AWReady  in  1.
- M_WData/WStrb/WLast/WValid  out  32/4/1/1; M_WReady  in  1.
- M_BID/BResp/BValid  in  4/2/1; M_BReady  out  1.
- M_ARID/ARAddr/ARLen/ARSize/ARBurst/ARValid  out  4/32/4/3/2/1; M_ARReady  in  1.
- M_RID/RData/RResp/RLast/RValid  in  4/32/2/1/1; M_RReady  out  1.

## Operation
- States: IDLE, RADDR, RDATA, WADDR, WRESP.
- In IDLE with cpu_req=1, the block latches addr {cpu_addr[31:2],2'b00}, len, wdata and wstrb. It then moves to WADDR if cpu_write=1, otherwise to RADDR.
- Fixed fields on both address channels: Size=3'b010, Burst=2'b01 (INCR), ID=MASTER_ID.
- RADDR
  - ARValid=1 and ARLen=latched len.
  - On ARValid&ARReady the block moves to RDATA.
- RDATA
  - RReady=1.
  - cpu_rdata=M_RData and cpu_rvalid=RValid&RReady (combinational).
  - A 4-bit beat counter increments on each handshake.
  - A handshake with RLast=1 asserts cpu_done, clears the counter and returns the FSM to IDLE.
- WADDR
  - AWValid=1 and WValid=1 are asserted together; AWLen=0, WLast=1.
  - Sticky flags aw_ok and w_ok record each handshake. The handshakes may land in the same cycle or in either order.
  - A channel stops driving Valid once its flag is set.
  - The FSM moves to WRESP when both handshakes are complete, counting the current cycle's handshakes.
- WRESP
  - BReady=1.
  - On BValid&BReady the block asserts cpu_done and returns to IDLE.
- cpu_stall
  - In IDLE: equals cpu_req.
  - In any other state: equals ~cpu_done.
- M_BID and M_RID are not checked.

## Timing
- Reset
  - FSM goes to IDLE.
  - Counter, flags, latched fields and cpu_err are cleared to 0.
  - All M_*Valid and M_*Ready outputs are 0.
  - cpu_rvalid=0, cpu_done=0, cpu_err=0.
  - Address/data outputs are 0.
- Request latency
  - With cpu_req at cycle 0, ARValid or AWValid is high from cycle 1.
  - With zero-wait slaves: a read of N beats completes at cycle 2+N-1+1; a write gets its B handshake at cycle 3.
- Handshake rules
  - Valids are registered and change only at clock edges.
  - Address, data and strobe stay stable while Valid=1 and Ready=0.
  - Readies are combinational from state only.
- cpu_done is combinational on the final handshake cycle, so the CPU may advance that cycle.
- The next request is sampled one cycle later in IDLE, which gives one bubble cycle between transactions.
- An RLast handshake ends the burst regardless of the counter value.
- Reset in any state aborts the transaction at the next edge. No cpu_done is generated for the aborted transaction.
- A cpu_req arriving during reset is ignored.

## Configuration
- AXI_MASTER_RESP_CHECK_EN
  - Defined: cpu_err is set, and held until reset, by any of:
    - an R handshake with RResp≠2'b00;
    - a B handshake with BResp≠2'b00;
    - an RLast handshake where counter≠latched len.
  - Undefined: cpu_err is tied to 0 and the check logic is absent.
  - Transaction flow is identical in both cases.

## Test plan
- Single read
  - Stimulus: addr 0x0000_1006, len 0; slave ARReady after 2 cycles; RData 0xDEADBEEF with RLast.
  - Required: ARAddr=0x0000_1004, ARLen=0; cpu_rvalid and cpu_done high in the same cycle; cpu_stall low that cycle.
- Burst read
  - Stimulus: len 3; slave inserts RValid gaps.
  - Required: exactly 4 cpu_rvalid pulses carrying data 1..4 in order; cpu_done only on the 4th; FSM returns to IDLE.
- Write ordering
  - Stimulus: WReady the cycle after AWValid rises, AWReady 3 cycles later.
  - Required: WValid drops after its handshake; AWValid stays up until accepted; WRESP entered only after both handshakes; BValid completes the write with cpu_done.
- Simultaneous handshakes
  - Stimulus: AWReady=WReady=1 in cycle 1; BValid in cycle 3.
  - Required: WRESP entered in cycle 2; WStrb=cpu_wstrb (e.g. 4'b0011); cpu_done in cycle 3.
- Reset mid-burst
  - Stimulus: ARESET asserted after the 2nd of 4 beats.
  - Required: all Valid/Ready outputs 0 next cycle; no cpu_done; a fresh read afterwards completes normally.
- Error check (macro defined)
  - Stimulus: RResp=2'b10, or RLast on beat 2 of len 3.
  - Required: cpu_err=1 and held until reset.
  - Same stimulus with macro undefined: cpu_err stays 0.

Source files
------------

// File: rtl/axi_master_port.sv
// AXI4 master port: one CPU request becomes one AXI read burst or one single-beat write.
// Optional response checking (sticky cpu_err) is built when AXI_MASTER_RESP_CHECK_EN is defined.
//
// state  | meaning
// IDLE   | waiting for cpu_req, fields latched on acceptance
// RADDR  | AR valid, waiting for ARReady
// RDATA  | accepting R beats until RLast
// WADDR  | AW and W valid, each dropped once accepted
// WRESP  | waiting for the B response
module axi_master_port #(
  parameter logic [3:0] MASTER_ID = 4'd0
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_len,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [3:0]  M_AWID,
  output logic [31:0] M_AWAddr,
  output logic [3:0]  M_AWLen,
  output logic [2:0]  M_AWSize,
  output logic [1:0]  M_AWBurst,
  output logic        M_AWValid,
  input  logic        M_AWReady,
  output logic [31:0] M_WData,
  output logic [3:0]  M_WStrb,
  output logic        M_WLast,
  output logic        M_WValid,
  input  logic        M_WReady,
  input  logic [3:0]  M_BID,
  input  logic [1:0]  M_BResp,
  input  logic        M_BValid,
  output logic        M_BReady,
  output logic [3:0]  M_ARID,
  output logic [31:0] M_ARAddr,
  output logic [3:0]  M_ARLen,
  output logic [2:0]  M_ARSize,
  output logic [1:0]  M_ARBurst,
  output logic        M_ARValid,
  input  logic        M_ARReady,
  input  logic [3:0]  M_RID,
  input  logic [31:0] M_RData,
  input  logic [1:0]  M_RResp,
  input  logic        M_RLast,
  input  logic        M_RValid,
  output logic        M_RReady
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WADDR = 3'd3,
    S_WRESP = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_len;
  logic [3:0]  r_wstrb;
  logic [3:0]  r_cnt;
  logic        r_arvalid;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_aw_ok;
  logic        r_w_ok;

  logic w_rready;
  logic w_bready;
  logic w_done;
  logic w_ar_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_r_hs;
  logic w_b_hs;
  logic w_aw_done;
  logic w_w_done;
  logic w_unused;

  assign w_ar_hs   = r_arvalid & M_ARReady;
  assign w_aw_hs   = r_awvalid & M_AWReady;
  assign w_w_hs    = r_wvalid & M_WReady;
  assign w_r_hs    = M_RValid & w_rready;
  assign w_b_hs    = M_BValid & w_bready;
  assign w_aw_done = r_aw_ok | w_aw_hs;
  assign w_w_done  = r_w_ok | w_w_hs;
  assign w_unused  = ^{M_BID, M_RID, M_BResp, M_RResp};

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rready    = 1'b0;
    w_bready    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req) w_state_nxt = cpu_write ? S_WADDR : S_RADDR;
      end
      S_RADDR: begin
        if (w_ar_hs) w_state_nxt = S_RDATA;
      end
      S_RDATA: begin
        w_rready = 1'b1;
        if (M_RValid && M_RLast) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WADDR: begin
        if (w_aw_done && w_w_done) w_state_nxt = S_WRESP;
      end
      S_WRESP: begin
        w_bready = 1'b1;
        if (M_BValid) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_len     <= '0;
      r_wstrb   <= '0;
      r_cnt     <= '0;
      r_arvalid <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_aw_ok   <= 1'b0;
      r_w_ok    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && cpu_req) begin
        r_addr    <= {cpu_addr[31:2], 2'b00};
        r_len     <= cpu_len;
        r_wdata   <= cpu_wdata;
        r_wstrb   <= cpu_wstrb;
        r_arvalid <= ~cpu_write;
        r_awvalid <= cpu_write;
        r_wvalid  <= cpu_write;
      end
      if (w_ar_hs) r_arvalid <= 1'b0;
      if (w_aw_hs) begin
        r_awvalid <= 1'b0;
        r_aw_ok   <= 1'b1;
      end
      if (w_w_hs) begin
        r_wvalid <= 1'b0;
        r_w_ok   <= 1'b1;
      end
      // flags only live for the duration of one write address phase
      if (r_state == S_WADDR && w_aw_done && w_w_done) begin
        r_aw_ok <= 1'b0;
        r_w_ok  <= 1'b0;
      end
      if (w_r_hs) r_cnt <= M_RLast ? 4'd0 : r_cnt + 4'd1;
    end
  end

`ifdef AXI_MASTER_RESP_CHECK_EN
  logic r_err;

  always_ff @(posedge ACLK) begin
    if (ARESET) r_err <= 1'b0;
    else if ((w_r_hs && ((M_RResp != 2'b00) || (M_RLast && (r_cnt != r_len)))) ||
             (w_b_hs && (M_BResp != 2'b00)))
      r_err <= 1'b1;
  end

  assign cpu_err = r_err;
`else
  assign cpu_err = 1'b0;
`endif

  // done is suppressed while reset is pending so an aborted transaction never completes
  assign cpu_done   = w_done & ~ARESET;
  assign cpu_stall  = (r_state == S_IDLE) ? cpu_req : ~cpu_done;
  assign cpu_rdata  = (r_state == S_RDATA) ? M_RData : 32'd0;
  assign cpu_rvalid = w_r_hs;

  assign M_ARID    = MASTER_ID;
  assign M_ARAddr  = r_addr;
  assign M_ARLen   = r_len;
  assign M_ARSize  = 3'b010;
  assign M_ARBurst = 2'b01;
  assign M_ARValid = r_arvalid;
  assign M_RReady  = w_rready;

  assign M_AWID    = MASTER_ID;
  assign M_AWAddr  = r_addr;
  assign M_AWLen   = 4'd0;
  assign M_AWSize  = 3'b010;
  assign M_AWBurst = 2'b01;
  assign M_AWValid = r_awvalid;
  assign M_WData   = r_wdata;
  assign M_WStrb   = r_wstrb;
  assign M_WLast   = 1'b1;
  assign M_WValid  = r_wvalid;
  assign M_BReady  = w_bready;

endmodule
